// File: rtl/fsm_memoria_rx.sv
// fsm_memoria_rx: receiving side of a four-phase send/ack handshake, storing words in a
// first-word-fall-through FIFO that drains through a valid/ready port. Rev 1.0
`default_nettype none

module fsm_memoria_rx #(
  parameter int DEPTH = 4,
  parameter int DW    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   send,
  input  logic [DW-1:0]                dado,
  output logic [1:0]                   ack,
  output logic [DW-1:0]                out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [15:0]                  xfer_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACKD = 2'b01,
    ILL2 = 2'b10,
    ILL3 = 2'b11
  } state_t;

  state_t          state_q;
  logic [1:0]      ack_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [DW-1:0]   mem [DEPTH];

  logic w_req, w_full, w_push, w_pop;

  // Full is judged on the registered level: a pop in this cycle cannot make room for this push.
  assign w_req  = (send == 2'b01);
  assign w_full = (level_q == LW'(DEPTH));
  assign w_push = (state_q == IDLE) && w_req && !w_full;
  assign w_pop  = (level_q != '0) && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(w_push);
    rd_ptr_d = rd_ptr_q + AW'(w_pop);
    cnt_d    = cnt_q + 16'(w_push);
    level_d  = level_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ack_q   <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_push) begin
            state_q <= ACKD;
            ack_q   <= 2'b01;
          end
        end
        ACKD: begin
          if (!w_req) begin
            state_q <= IDLE;
            ack_q   <= 2'b00;
          end
        end
        default: begin
          state_q <= IDLE;
          ack_q   <= 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is intentionally not reset; out_data is only meaningful while out_valid is high.
  always_ff @(posedge clk) begin
    if (w_push) mem[wr_ptr_q] <= dado;
  end

  assign ack       = ack_q;
  assign out_data  = mem[rd_ptr_q];
  assign out_valid = (level_q != '0);
  assign level     = level_q;
  assign xfer_cnt  = cnt_q;

endmodule

`default_nettype wire
